// File: rtl/wired_lsu_sb_drain.sv
// Store-buffer drain engine: writes retired SB entries into the dcache data SRAM, refilling on miss.
// Optional perf counters are enabled with `define WIRED_SB_DRAIN_PERF_EN.
module wired_lsu_sb_drain #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WAY_CNT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                commit_i,
  input  logic                top_valid_i,
  input  logic [WAY_CNT-1:0]  top_hit_i,
  input  logic [ADDR_W-1:0]   top_addr_i,
  input  logic [DATA_W-1:0]   top_wdata_i,
  input  logic [DATA_W/8-1:0] top_strb_i,
  output logic                sb_pop_o,
  output logic                sram_req_o,
  input  logic                sram_gnt_i,
  output logic [WAY_CNT-1:0]  sram_way_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  output logic [DATA_W/8-1:0] sram_strb_o,
  output logic                refill_req_o,
  output logic [ADDR_W-1:0]   refill_addr_o,
  input  logic                refill_ack_i,
  input  logic                refill_done_i,
`ifdef WIRED_SB_DRAIN_PERF_EN
  output logic [31:0]         perf_drain_o,
  output logic [31:0]         perf_miss_o,
`endif
  output logic                idle_o
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int LINE_OFF = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    MISS_REQ   = 3'd2,
    MISS_WAIT  = 3'd3,
    FLUSH_WAIT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                latch_en;
  logic [WAY_CNT-1:0]  way_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [STRB_W-1:0]   strb_p0;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != 3'd0 && top_valid_i) begin
          latch_en = 1'b1;
          state_d  = (|top_hit_i) ? WRITE : MISS_REQ;
        end
      end
      WRITE: begin
        if (sram_gnt_i) state_d = IDLE;
      end
      MISS_REQ: begin
        // An accepted refill must be waited out even under flush, since it will still land.
        if (refill_ack_i) begin
          if (refill_done_i)  state_d = IDLE;
          else if (flush_i)   state_d = FLUSH_WAIT;
          else                state_d = MISS_WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      MISS_WAIT: begin
        if (refill_done_i)  state_d = IDLE;
        else if (flush_i)   state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (refill_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({commit_i, sb_pop_o})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry capture stage: fields held stable for the whole SRAM or refill handshake.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      way_p0   <= top_hit_i;
      addr_p0  <= top_addr_i;
      wdata_p0 <= top_wdata_i;
      strb_p0  <= top_strb_i;
    end
  end

  // Data outputs are gated by state so they read zero outside their handshake.
  assign sram_req_o    = (state_q == WRITE);
  assign sb_pop_o      = sram_req_o && sram_gnt_i;
  assign sram_way_o    = sram_req_o ? way_p0   : '0;
  assign sram_addr_o   = sram_req_o ? addr_p0  : '0;
  assign sram_wdata_o  = sram_req_o ? wdata_p0 : '0;
  assign sram_strb_o   = sram_req_o ? strb_p0  : '0;
  assign refill_req_o  = (state_q == MISS_REQ);
  assign refill_addr_o = refill_req_o ? {addr_p0[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}} : '0;
  assign idle_o        = (state_q == IDLE) && (cnt_q == 3'd0);

`ifdef WIRED_SB_DRAIN_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_drain_o <= 32'd0;
      perf_miss_o  <= 32'd0;
    end else begin
      if (sb_pop_o) perf_drain_o <= perf_drain_o + 32'd1;
      if (state_q != MISS_REQ && state_d == MISS_REQ) perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(commit_i && !sb_pop_o && cnt_q == 3'd4));
  a_top_present: assert property (@(posedge clk) disable iff (rst)
    !(state_q == IDLE && cnt_q != 3'd0 && !top_valid_i));

endmodule
